skel_clock_gen: RTL and testbench



---
 rtl/skel_clock_gen_pkg.sv | 33 +++
 rtl/skel_clock_gen_rst_sync.sv | 26 ++
 rtl/skel_clock_gen.sv | 120 ++++++++++++
 tb/tb_skel_clock_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/skel_clock_gen_pkg.sv
// Shared types for the skeleton clock-phase sequencer: FSM states, phase slots and phase decode.
package skel_clk_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SYNC  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } clk_state_e;

  localparam logic [1:0] PH_PROC_HI0 = 2'd0;
  localparam logic [1:0] PH_DMEM     = 2'd1;
  localparam logic [1:0] PH_REGF     = 2'd2;
  localparam logic [1:0] PH_IMEM     = 2'd3;

  typedef struct packed {
    logic imem;
    logic dmem;
    logic regf;
    logic proc;
  } phase_clks_t;

  // processor_clock is high for the first two slots, the other clocks own one slot each
  function automatic phase_clks_t phase_decode(input logic [1:0] ph);
    phase_clks_t c;
    c.proc = (ph == PH_PROC_HI0) || (ph == PH_DMEM);
    c.dmem = (ph == PH_DMEM);
    c.regf = (ph == PH_REGF);
    c.imem = (ph == PH_IMEM);
    return c;
  endfunction

endpackage

// File: rtl/skel_clock_gen_rst_sync.sv
// Two-flop reset synchroniser: asynchronous assert, release two clock edges after the input falls.
module skel_rst_sync (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_o,
  output logic rel_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_o = sync_q;
  // High on the edge where sync_q clears, so a consumer can switch in step with the second flop
  assign rel_o = ~meta_q;

endmodule

// File: rtl/skel_clock_gen.sv
// Clock-phase and reset sequencer for the processor skeleton (4-phase registered clocks, warm-up hold).
// Optional stall input enabled by defining SKEL_STALL_EN.
module skel_clock_gen
  import skel_clk_pkg::*;
#(
  parameter int unsigned RST_HOLD = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
`ifdef SKEL_STALL_EN
  input  logic             stall,
`endif
  output logic             imem_clock,
  output logic             dmem_clock,
  output logic             regfile_clock,
  output logic             processor_clock,
  output logic             proc_reset,
  output logic             ready,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RST_HOLD);

  clk_state_e    state_q, state_d;
  logic [1:0]    ph_q, ph_d;
  logic [HW-1:0] hold_q, hold_d;
  phase_clks_t   clks_q, clks_d;
  logic          proc_rst_q, proc_rst_d;
  logic          ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          sync_rst;
  logic          sync_rel;
  logic          stall_now;

  skel_rst_sync u_rst_sync (
    .clk_i (clock),
    .rst_i (reset),
    .rst_o (sync_rst),
    .rel_o (sync_rel)
  );

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    hold_d     = hold_q;
    clks_d     = '0;
    proc_rst_d = proc_rst_q;
    ready_d    = ready_q;
    cnt_d      = cnt_q;
    stall_now  = 1'b0;
`ifdef SKEL_STALL_EN
    stall_now  = (state_q == ST_RUN) && (ph_q == PH_IMEM) && stall;
`endif
    unique case (state_q)
      ST_RESET: begin
        if (sync_rel) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!sync_rst) begin
          state_d = ST_HOLD;
          ph_d    = PH_PROC_HI0;
          clks_d  = phase_decode(PH_PROC_HI0);
        end
      end
      ST_HOLD: begin
        ph_d   = ph_q + 2'd1;
        clks_d = phase_decode(ph_d);
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        // Leaving reset on the 1->2 step lands on a processor_clock falling edge
        if ((ph_q == PH_DMEM) && (hold_q == HOLD_MAX)) begin
          state_d    = ST_RUN;
          proc_rst_d = 1'b0;
          ready_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (stall_now) begin
          ph_d   = ph_q;
          clks_d = '0;
        end else begin
          ph_d   = ph_q + 2'd1;
          clks_d = phase_decode(ph_d);
          if (ph_q == PH_IMEM) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RESET;
      ph_q       <= PH_IMEM;
      hold_q     <= '0;
      clks_q     <= '0;
      proc_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      hold_q     <= hold_d;
      clks_q     <= clks_d;
      proc_rst_q <= proc_rst_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_clock      = clks_q.imem;
  assign dmem_clock      = clks_q.dmem;
  assign regfile_clock   = clks_q.regf;
  assign processor_clock = clks_q.proc;
  assign proc_reset      = proc_rst_q;
  assign ready           = ready_q;
  assign cycle_count     = cnt_q;

endmodule

// File: tb/tb_skel_clock_gen.sv
// Directed bench for skel_clock_gen: startup timing, phase pattern, reset pulses, counter wrap, stall.
module tb_skel_clock_gen;

  logic clock = 1'b0;
  logic reset = 1'b1;
`ifdef SKEL_STALL_EN
  logic stall = 1'b0;
`endif

  logic imem_clock, dmem_clock, regfile_clock, processor_clock, proc_reset, ready;
  logic [31:0] cycle_count;
  logic imem4, dmem4, regf4, proc4, prst4, ready4;
  logic [3:0] cc4;

  int n_cmp = 0;
  int n_bad = 0;
  int ph_exp = 0;
  int exp_cc = 0;

  always #5 clock = ~clock;

  skel_clock_gen #(.RST_HOLD(8), .CNT_W(32)) dut (
    .clock           (clock),
    .reset           (reset),
`ifdef SKEL_STALL_EN
    .stall           (stall),
`endif
    .imem_clock      (imem_clock),
    .dmem_clock      (dmem_clock),
    .regfile_clock   (regfile_clock),
    .processor_clock (processor_clock),
    .proc_reset      (proc_reset),
    .ready           (ready),
    .cycle_count     (cycle_count)
  );

  skel_clock_gen #(.RST_HOLD(8), .CNT_W(4)) dut4 (
    .clock           (clock),
    .reset           (reset),
`ifdef SKEL_STALL_EN
    .stall           (stall),
`endif
    .imem_clock      (imem4),
    .dmem_clock      (dmem4),
    .regfile_clock   (regf4),
    .processor_clock (proc4),
    .proc_reset      (prst4),
    .ready           (ready4),
    .cycle_count     (cc4)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] obs_vec();
    return {imem_clock, dmem_clock, regfile_clock, processor_clock, proc_reset, ready};
  endfunction

  function automatic logic [5:0] obs4_vec();
    return {imem4, dmem4, regf4, proc4, prst4, ready4};
  endfunction

  // {imem, dmem, regfile, processor, proc_reset, ready}
  function automatic logic [5:0] exp_vec(input int ph, input bit clk_on, input bit prst, input bit rdy);
    logic [3:0] c;
    c = 4'b0000;
    if (clk_on) c = {ph == 3, ph == 1, ph == 2, ph < 2};
    return {c, prst, rdy};
  endfunction

  task automatic test_reset();
    repeat (3) step();
    n_cmp++;
    if (obs_vec() !== 6'b000010) begin
      n_bad++; $display("FAIL reset_outs: got %b want %b", obs_vec(), 6'b000010);
    end
    n_cmp++;
    if (cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL reset_cc: got %0d want 0", cycle_count);
    end
    n_cmp++;
    if (obs4_vec() !== 6'b000010) begin
      n_bad++; $display("FAIL reset_outs4: got %b want %b", obs4_vec(), 6'b000010);
    end
  endtask

  // Releases reset (if still high) and checks the 13 edges up to entry into RUN
  task automatic test_startup(input string tag);
    logic [5:0] e;
    reset = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      step();
      if (i < 3) e = exp_vec(0, 1'b0, 1'b1, 1'b0);
      else       e = exp_vec((i - 3) % 4, 1'b1, i < 13, i >= 13);
      n_cmp++;
      if (obs_vec() !== e) begin
        n_bad++; $display("FAIL %s_edge%0d: got %b want %b", tag, i, obs_vec(), e);
      end
      n_cmp++;
      if (obs4_vec() !== e) begin
        n_bad++; $display("FAIL %s_edge%0d_w4: got %b want %b", tag, i, obs4_vec(), e);
      end
      n_cmp++;
      if (cycle_count !== 32'd0 || cc4 !== 4'd0) begin
        n_bad++; $display("FAIL %s_cc%0d: got %0d/%0d want 0", tag, i, cycle_count, cc4);
      end
    end
    ph_exp = 2;
    exp_cc = 0;
  endtask

  task automatic run_check(input int n, input string tag);
    logic [5:0] e;
    logic [31:0] ecc;
    for (int i = 0; i < n; i++) begin
      ph_exp = (ph_exp + 1) % 4;
      if (ph_exp == 0) exp_cc++;
      step();
      e = exp_vec(ph_exp, 1'b1, 1'b0, 1'b1);
      ecc = 32'(exp_cc);
      n_cmp++;
      if (obs_vec() !== e || obs4_vec() !== e) begin
        n_bad++; $display("FAIL %s_outs%0d: got %b/%b want %b", tag, i, obs_vec(), obs4_vec(), e);
      end
      n_cmp++;
      if (cycle_count !== ecc || cc4 !== ecc[3:0]) begin
        n_bad++; $display("FAIL %s_cc%0d: got %0d/%0d want %0d/%0d", tag, i, cycle_count, cc4, ecc, ecc[3:0]);
      end
    end
  endtask

  task automatic test_free_run();
    run_check(40, "freerun");
    n_cmp++;
    if (cycle_count !== 32'd10) begin
      n_bad++; $display("FAIL freerun_cc10: got %0d want 10", cycle_count);
    end
  endtask

  task automatic test_reset_midrun();
    reset = 1'b1;
    repeat (2) step();
    test_startup("start2");
    run_check(18, "pre_pulse");
    n_cmp++;
    if (cycle_count !== 32'd5) begin
      n_bad++; $display("FAIL pulse_cc5: got %0d want 5", cycle_count);
    end
    run_check(1, "pre_pulse_ph1");
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs_vec() !== 6'b000010 || cycle_count !== 32'd0) begin
      n_bad++; $display("FAIL pulse_async: got %b cc %0d want 000010 cc 0", obs_vec(), cycle_count);
    end
    #9;
    n_cmp++;
    if (obs_vec() !== 6'b000010 || cc4 !== 4'd0) begin
      n_bad++; $display("FAIL pulse_held: got %b cc4 %0d want 000010 cc4 0", obs_vec(), cc4);
    end
    test_startup("after_pulse");
  endtask

  task automatic test_glitch();
    run_check(3, "pre_glitch");
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== 6'b000010 || obs4_vec() !== 6'b000010) begin
      n_bad++; $display("FAIL glitch: got %b/%b want 000010", obs_vec(), obs4_vec());
    end
    test_startup("after_glitch");
  endtask

  task automatic test_cnt_wrap();
    run_check(58, "to15");
    n_cmp++;
    if (cc4 !== 4'd15 || cycle_count !== 32'd15) begin
      n_bad++; $display("FAIL wrap_15: got %0d/%0d want 15/15", cc4, cycle_count);
    end
    run_check(4, "to0");
    n_cmp++;
    if (cc4 !== 4'd0 || cycle_count !== 32'd16) begin
      n_bad++; $display("FAIL wrap_0: got %0d/%0d want 0/16", cc4, cycle_count);
    end
    run_check(4, "to1");
    n_cmp++;
    if (cc4 !== 4'd1 || cycle_count !== 32'd17) begin
      n_bad++; $display("FAIL wrap_1: got %0d/%0d want 1/17", cc4, cycle_count);
    end
  endtask

`ifdef SKEL_STALL_EN
  task automatic test_stall();
    reset = 1'b1;
    repeat (2) step();
    test_startup("stall_start");
    run_check(1, "to_ph3");
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if (obs_vec() !== 6'b000001 || cycle_count !== 32'd0) begin
        n_bad++; $display("FAIL stall%0d: got %b cc %0d want 000001 cc 0", i, obs_vec(), cycle_count);
      end
    end
    stall = 1'b0;
    run_check(8, "resume");
  endtask

  task automatic test_stall_hold();
    reset = 1'b1;
    repeat (2) step();
    stall = 1'b1;
    test_startup("stall_hold");
    stall = 1'b0;
    run_check(4, "stall_hold_run");
  endtask
`endif

  initial begin
    test_reset();
    test_startup("start1");
    test_free_run();
    test_reset_midrun();
    test_glitch();
    test_cnt_wrap();
`ifdef SKEL_STALL_EN
    test_stall();
    test_stall_hold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
